// File: rtl/pp_acc_pkg.sv
// Shared types and constants for the partial-product accumulator.
//   PP_W    : default operand width (rows, row width)
//   row_t   : one partial-product row
//   prod_t  : full-width product
//   state_e : accumulator FSM states
package pp_acc_pkg;

  localparam int unsigned PP_W = 8;

  typedef logic [PP_W-1:0]   row_t;
  typedef logic [2*PP_W-1:0] prod_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

endpackage

// File: rtl/pp_next_row.sv
// Priority encoder used by the zero-skip build of pp_accumulator.
// Finds the lowest set mask bit above idx (or at/above idx when incl is set).
//   mask : one bit per row, set where the row is nonzero
//   idx  : current row index
//   incl : also consider bit idx itself (used to find the first row)
//   nxt  : index of the found bit (0 when none)
//   last : no qualifying bit exists
module pp_next_row
  import pp_acc_pkg::*;
#(
  parameter int unsigned W  = PP_W,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  input  logic [IW-1:0] idx,
  input  logic          incl,
  output logic [IW-1:0] nxt,
  output logic          last
);

  always_comb begin
    nxt  = '0;
    last = 1'b1;
    // Scan downward so the lowest qualifying bit is the one that sticks.
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(idx)) || (incl && (i == int'(idx))))) begin
        nxt  = IW'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pp_accumulator.sv
// Reduces one set of W partial-product rows to a 2W-bit product by sequential
// shift-add, one row per cycle, with valid/ready handshakes on both sides.
// Optional feature macro: ZERO_SKIP_EN (skip all-zero rows during accumulation).
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   pp_valid   : pp_rows holds a valid row set
//   pp_ready   : ready to accept a row set (idle only)
//   pp_rows    : row i at [i*W +: W], row 0 has weight 2^0
//   prod_valid : prod holds the result
//   prod_ready : sink accepts the product
//   prod       : unsigned product, sum(row_i << i)
//   busy       : job in progress (accumulating or holding a result)
module pp_accumulator
  import pp_acc_pkg::*;
#(
  parameter int unsigned W = PP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [W*W-1:0]   pp_rows,
  output logic             prod_valid,
  input  logic             prod_ready,
  output logic [2*W-1:0]   prod,
  output logic             busy
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q, state_d;
  logic [W*W-1:0]  rows_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  addend;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_next;
  logic [IW-1:0]   idx_first;
  logic [W-1:0]    row_cur;
  logic            accept;
  logic            step;
  logic            last_step;
  logic            start_empty;

  assign accept  = pp_valid && (state_q == StIdle);
  assign step    = (state_q == StAccum);
  assign row_cur = rows_q[idx_q*W +: W];
  assign addend  = {{W{1'b0}}, row_cur} << idx_q;

`ifdef ZERO_SKIP_EN
  logic [W-1:0] mask_q;
  logic [W-1:0] mask_in;

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < int'(W); i++) begin
      mask_in[i] = |pp_rows[i*W +: W];
    end
  end

  // Next nonzero row after the current one; last_step when none remain.
  pp_next_row #(
    .W (W)
  ) u_step (
    .mask (mask_q),
    .idx  (idx_q),
    .incl (1'b0),
    .nxt  (idx_next),
    .last (last_step)
  );

  // First nonzero row of the incoming set; an empty set goes straight to done.
  pp_next_row #(
    .W (W)
  ) u_first (
    .mask (mask_in),
    .idx  ({IW{1'b0}}),
    .incl (1'b1),
    .nxt  (idx_first),
    .last (start_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= mask_in;
    end
  end
`else
  assign idx_next    = idx_q + 1'b1;
  assign idx_first   = '0;
  assign last_step   = (idx_q == IW'(W - 1));
  assign start_empty = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = start_empty ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (prod_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    pp_ready   = (state_q == StIdle);
    prod_valid = (state_q == StDone);
    busy       = (state_q != StIdle);
    prod       = acc_q;
  end

  // Datapath: enabled only on capture or an accumulate step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      rows_q <= pp_rows;
      acc_q  <= '0;
      idx_q  <= idx_first;
    end else if (step) begin
      acc_q <= acc_q + addend;
      // Hold idx on the final row so it never wraps.
      if (!last_step) begin
        idx_q <= idx_next;
      end
    end
  end

endmodule
